// File: rtl/openram_scan_master.sv
// ============================================================================
// Module   : openram_scan_master
// Brief    : Serializes a command word into the OpenRAM test-chip scan chain,
//            optionally strobes an SRAM capture and shifts the result back.
// Revision : 1.0
// ============================================================================
`default_nettype none

module openram_scan_master #(
  parameter int SELECT_SIZE   = 4,
  parameter int ADDR_SIZE     = 16,
  parameter int DATA_SIZE     = 32,
  parameter int WMASK_SIZE    = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int PORT_SIZE     = ADDR_SIZE + DATA_SIZE + WMASK_SIZE + 2,
  parameter int TOTAL_SIZE    = SELECT_SIZE + 2 * PORT_SIZE
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [TOTAL_SIZE-1:0] cmd_data,
  input  logic                  cmd_readback,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [TOTAL_SIZE-1:0] rsp_data,
  output logic                  busy,
  output logic                  gpio_in,
  output logic                  gpio_scan,
  output logic                  gpio_sram_load,
  output logic                  global_csr,
  input  logic                  gpio_out
);

  localparam int CNT_W    = $clog2(TOTAL_SIZE + 1);
  localparam int c_CSB0   = PORT_SIZE + WMASK_SIZE + 1;
  localparam int c_CSB1   = WMASK_SIZE + 1;
  localparam logic [CNT_W-1:0] c_LAST_SHIFT  = CNT_W'(TOTAL_SIZE - 1);
  localparam logic [CNT_W-1:0] c_LAST_SETTLE = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_SETTLE    = 3'd2,
    S_LOAD      = 3'd3,
    S_SHIFT_OUT = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [TOTAL_SIZE-1:0] r_tx_sr;
  logic [TOTAL_SIZE-1:0] r_park_sr;
  logic [TOTAL_SIZE-1:0] r_rx_sr;
  logic                  r_rb;
  logic                  r_gpio_in;
  logic                  r_gpio_scan;
  logic                  r_gpio_sram_load;
  logic                  r_global_csr;
  logic                  r_rsp_valid;
  logic                  r_busy;
  logic                  r_cmd_ready;
  logic [TOTAL_SIZE-1:0] w_park;

  // Shifting the command back in with both chip selects high leaves the chip idle.
  always_comb begin
    w_park         = cmd_data;
    w_park[c_CSB0] = 1'b1;
    w_park[c_CSB1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_tx_sr          <= '0;
      r_park_sr        <= '0;
      r_rx_sr          <= '0;
      r_rb             <= 1'b0;
      r_gpio_in        <= 1'b0;
      r_gpio_scan      <= 1'b0;
      r_gpio_sram_load <= 1'b0;
      r_global_csr     <= 1'b1;
      r_rsp_valid      <= 1'b0;
      r_busy           <= 1'b0;
      r_cmd_ready      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_tx_sr     <= cmd_data;
            r_park_sr   <= w_park;
            r_rb        <= cmd_readback;
            r_cnt       <= '0;
            r_state     <= S_SHIFT_IN;
            r_gpio_scan <= 1'b1;
            r_gpio_in   <= cmd_data[TOTAL_SIZE-1];
            r_busy      <= 1'b1;
            r_cmd_ready <= 1'b0;
          end
        end
        S_SHIFT_IN: begin
          // gpio_in is registered, so it is loaded with the bit that becomes MSB next.
          r_tx_sr   <= r_tx_sr << 1;
          r_cnt     <= r_cnt + 1'b1;
          r_gpio_in <= r_tx_sr[TOTAL_SIZE-2];
          if (r_cnt == c_LAST_SHIFT) begin
            r_cnt       <= '0;
            r_gpio_scan <= 1'b0;
            r_gpio_in   <= 1'b0;
            if (r_rb) begin
              r_state      <= S_SETTLE;
              r_global_csr <= 1'b0;
            end else begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
            end
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST_SETTLE) begin
            r_cnt            <= '0;
            r_state          <= S_LOAD;
            r_gpio_sram_load <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state          <= S_SHIFT_OUT;
          r_gpio_sram_load <= 1'b0;
          r_global_csr     <= 1'b1;
          r_gpio_scan      <= 1'b1;
          r_gpio_in        <= r_park_sr[TOTAL_SIZE-1];
        end
        S_SHIFT_OUT: begin
          r_park_sr <= r_park_sr << 1;
          r_rx_sr   <= {r_rx_sr[TOTAL_SIZE-2:0], gpio_out};
          r_cnt     <= r_cnt + 1'b1;
          r_gpio_in <= r_park_sr[TOTAL_SIZE-2];
          if (r_cnt == c_LAST_SHIFT) begin
            r_cnt       <= '0;
            r_gpio_scan <= 1'b0;
            r_gpio_in   <= 1'b0;
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end
        default: begin
          r_state          <= S_IDLE;
          r_cnt            <= '0;
          r_gpio_in        <= 1'b0;
          r_gpio_scan      <= 1'b0;
          r_gpio_sram_load <= 1'b0;
          r_global_csr     <= 1'b1;
          r_rsp_valid      <= 1'b0;
          r_busy           <= 1'b0;
          r_cmd_ready      <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rx_sr;
  assign busy           = r_busy;
  assign gpio_in        = r_gpio_in;
  assign gpio_scan      = r_gpio_scan;
  assign gpio_sram_load = r_gpio_sram_load;
  assign global_csr     = r_global_csr;

endmodule

`default_nettype wire

// File: doc/openram_scan_master.md
# openram_scan_master

Host-side driver for the OpenRAM test-chip GPIO scan protocol. It takes a parallel command word and serializes it MSB-first onto `gpio_in`/`gpio_scan`, so the test-chip scan register holds the command. For read-back commands it then lets the SRAM access settle, pulses `gpio_sram_load`, and shifts the captured result back out of `gpio_out` into a parallel response word. It sits in the test harness / management-side logic, on the same `clk` as the test chip.

## Interface
Parameters:
- `SELECT_SIZE`, default 4: chip-select field width.
- `ADDR_SIZE`, default 16: per-port address width.
- `DATA_SIZE`, default 32: per-port data width.
- `WMASK_SIZE`, default 4: per-port write-mask width.
- `SETTLE_CYCLES`, default 4: cycles between end of shift-in and the load pulse. Must be ≥1.
- Derived: `PORT_SIZE` = ADDR+DATA+WMASK+2 (54); `TOTAL_SIZE` = SELECT+2·PORT (112).

Ports:
- `clk` in 1: clock, shared with the test chip.
- `resetn` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_data` in TOTAL_SIZE: scan word, with the same field layout as the chip register.
- `cmd_readback` in 1: 1 = do settle/load/shift-out; 0 = write-only.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response accepted.
- `rsp_data` out TOTAL_SIZE: captured chip register contents.
- `busy` out 1: high whenever the state is not IDLE.
- `gpio_in` out 1: serial data to the chip.
- `gpio_scan` out 1: shift enable to the chip.
- `gpio_sram_load` out 1: result-capture strobe to the chip.
- `global_csr` out 1: global chip-select disable to the chip (1 = all SRAMs deselected).
- `gpio_out` in 1: serial data from the chip (chip register MSB).

## Operation
- **States:** IDLE, SHIFT_IN, SETTLE, LOAD, SHIFT_OUT, RESP. State counter width is clog2(TOTAL_SIZE+1).
- **Output registration:** all outputs come from flops or decoded state flops. There is no combinational path from inputs to outputs.
- **IDLE:**
  - On `cmd_valid && cmd_ready`: latch `tx_sr`=`cmd_data` and `rb`=`cmd_readback`, clear the counter, go to SHIFT_IN.
  - Build `park_sr` = `cmd_data` with bit PORT_SIZE+WMASK_SIZE+1 (csb0) and bit WMASK_SIZE+1 (csb1) forced to 1.
- **SHIFT_IN (TOTAL_SIZE cycles):**
  - `gpio_scan`=1 and `gpio_in`=`tx_sr[TOTAL_SIZE-1]`.
  - Each edge: `tx_sr` shifts left by 1 and the counter increments.
  - At the end: if `rb`, go to SETTLE; otherwise go to IDLE (no response).
- **SETTLE (SETTLE_CYCLES cycles):** `gpio_scan`=0 and `global_csr`=0, so the selected SRAM is enabled.
- **LOAD (1 cycle):** `gpio_sram_load`=1 and `global_csr`=0.
- **SHIFT_OUT (TOTAL_SIZE cycles):**
  - `gpio_scan`=1 and `gpio_in`=`park_sr[TOTAL_SIZE-1]`; `park_sr` shifts left each edge.
  - Each edge: `rx_sr` <= {`rx_sr`[TOTAL_SIZE-2:0], `gpio_out`}.
  - After the last edge, `rx_sr` equals the chip register value as of LOAD, MSB-first. The chip register is left holding `park_sr`, so both ports are deselected.
- **RESP:**
  - `rsp_valid`=1 and `rsp_data`=`rx_sr`, both held stable until `rsp_ready`.
  - On handshake, go to IDLE.
- **`global_csr`:** 1 in IDLE, SHIFT_IN, SHIFT_OUT and RESP; 0 only in SETTLE and LOAD.
- **`cmd_valid` while busy:** ignored, not queued.

## Timing
- **Reset values:** state=IDLE, counter=0, `gpio_in`=0, `gpio_scan`=0, `gpio_sram_load`=0, `global_csr`=1, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `cmd_ready`=1 (after reset).
- **Cycle timeline, with accept at edge E0 (N=TOTAL_SIZE, S=SETTLE_CYCLES):**
  - `gpio_scan` is high in cycles 1..N.
  - SETTLE occupies cycles N+1..N+S.
  - LOAD is cycle N+S+1.
  - SHIFT_OUT occupies cycles N+S+2..2N+S+1.
  - `rsp_valid` first goes high in cycle 2N+S+2.
  - A write-only command returns to IDLE at cycle N+1.
- **`gpio_sram_load`:** exactly one cycle wide; never coincident with `gpio_scan`.
- **After a response:** the next command can be accepted in the cycle after the `rsp_valid && rsp_ready` edge.
- **Reset mid-operation:** at the reset edge, all outputs take their reset values. Any partial shift is abandoned and no response is produced.

## Test plan
- **Write-only, bit alignment:** reset, then send `cmd_data`=0x00A5…(112-bit pattern) with `cmd_readback`=0 to a behavioral chip register model -> after 112 scan cycles the model register equals `cmd_data`; `busy` falls at cycle 113; `gpio_sram_load` is never asserted.
- **Readback:** chip model returns `sram3_data0`=0xDEADBEEF and `sram3_data1`=0x12345678 for chip_select=3 -> `rsp_data` carries those values in the din0/din1 fields, other fields are unchanged, and `rsp_valid` is first high at cycle 2·112+4+2=230.
- **Parking:** after readback, the chip model has csb0 and csb1 bits = 1 and the remaining bits equal to the command; `global_csr`=0 only in cycles 113–117.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles -> `rsp_valid` and `rsp_data` stay stable and `cmd_valid` is ignored; `cmd_ready` rises the cycle after `rsp_ready`=1.
- **Reset mid-shift:** assert `resetn`=0 at SHIFT_IN cycle 50 -> next cycle `gpio_scan`=0, `global_csr`=1, `busy`=0, and no `rsp_valid` follows.
- **Back-to-back:** `cmd_valid` held high with alternating readback=1/0 commands -> each completes with the correct latency and there is no overlap between transactions.
